fft_bitrev_reorder: RTL and testbench
=====================================

Name: fft_bitrev_reorder

Overview:
- Natural-order reorder stage, placed directly downstream of the pipelined 1024-point FFT core.
- It replaces the stub that passes the core's output straight through.
- The FFT core emits each frame in bit-reversed index order. This block re-emits each frame in natural frequency order.
- It uses a ping-pong (double-bank) buffer with one complex sample in and one out per i_ce.
- It keeps the core's i_ce / sync conventions so it can be inserted between the last FFT stage and the output registers.

Parameters:
- LGSIZE, 10: log2 of the FFT frame length N (N = 1024 by default).
- WIDTH, 32: bits per complex sample; real part in the upper half, imaginary part in the lower half; passed through untouched.

Ports:
- i_clk  in  1  clock; all logic is synchronous to its rising edge.
- i_reset  in  1  synchronous, active-high reset; clock is i_clk.
- i_ce  in  1  clock enable; one sample is accepted and one produced per cycle in which it is high.
- i_in  in  WIDTH  sample from the FFT core, in bit-reversed frame order.
- i_sync  in  1  high with the first sample (position 0) of an input frame.
- o_out  out  WIDTH  registered sample, in natural frequency order.
- o_sync  out  1  registered; high with natural-order bin 0 of each valid output frame.

Behaviour:
- Storage: 2N x WIDTH memory organised as bank 0 and bank 1.
- Write pointer wr_addr has LGSIZE+1 bits; its MSB selects the bank.
- State machine has three states:
  - WAIT_SYNC (reset state): i_in is discarded and wr_addr is held at 0. On (i_ce && i_sync), write i_in to address 0, set wr_addr to 1, and go to FILL.
  - FILL: on each i_ce, write mem[wr_addr] <= i_in and increment wr_addr. When wr_addr goes from N-1 to N, go to RUN.
  - RUN: on each i_ce, write mem[wr_addr] <= i_in and increment wr_addr, wrapping from 2N-1 to 0.
- Read address: rd_addr = {~wr_addr[LGSIZE], bitrev(wr_addr[LGSIZE-1:0])}.
  - The read always targets the bank not being written.
  - Each frame is therefore read in natural order, since bin k sits at position bitrev(k).
- Output registers, updated only on i_ce:
  - o_out <= mem[rd_addr] in RUN; o_out holds its value in WAIT_SYNC and FILL.
  - o_sync <= (state == RUN) && (wr_addr[LGSIZE-1:0] == 0).
- Latency: natural bin k of a frame appears on o_out after the i_ce edge on which input position k of the next frame is accepted. That is exactly N i_ce cycles, plus one register stage.
- In RUN, output runs back-to-back with no gaps between frames.
- i_ce low: no write, no pointer change, and o_out / o_sync hold. o_sync is not pulsed by a cycle with i_ce low.
- i_sync after WAIT_SYNC is ignored; frame alignment is locked until reset. A misaligned i_sync must not disturb wr_addr.
- Reset, including mid-frame:
  - Next cycle: state = WAIT_SYNC, wr_addr = 0, o_out = 0, o_sync = 0.
  - Memory contents are don't-care; no stale data may be output before a fresh FILL completes.
- Simultaneous i_reset and i_ce: reset wins and the sample is dropped.
- Widths: no arithmetic on data; WIDTH bits are passed verbatim.
- bitrev is a pure wire permutation, bit i mapping to bit LGSIZE-1-i.

Decomposition:
- Shared package fft_pkg holds:
  - the LGSIZE / WIDTH defaults;
  - the state encoding: WAIT_SYNC = 2'd0, FILL = 2'd1, RUN = 2'd2;
  - a parameterised bitrev function.
- One sub-module, fft_bitrev_ram: simple dual-port RAM, 2N x WIDTH, with one write port and one registered read port, both gated by i_ce. Written so that it infers block RAM.
- The top level holds the FSM, pointers and sync logic.

Test Plan:
- LGSIZE=3, reset then 2 frames. Input position p carries value bitrev(p), i.e. 0,4,2,6,1,5,3,7, with i_sync on p=0. Required: o_out = 0,1,…,7 starting on the 9th i_ce, with o_sync high on the value 0 only.
- LGSIZE=3, 5 samples with i_sync=0, then a sync'd frame. Required: the 5 samples are discarded, and the first o_sync occurs exactly 8 i_ce cycles after the i_sync cycle.
- LGSIZE=3, i_ce low for 3 cycles in mid-frame during RUN. Required: o_out/o_sync frozen for those cycles, no sample lost, and the output sequence identical to the ungated run.
- LGSIZE=3, 4 continuous frames with i_sync pulses every 8 ce, plus one spurious i_sync at position 3 of frame 2. Required: o_sync every 8 ce, back-to-back, alignment unchanged.
- LGSIZE=3, i_reset asserted at position 5 of frame 2. Required: o_out=0 and o_sync=0 on the next cycle, and no output until a new i_sync plus 8 ce.
- Default LGSIZE=10, frame with value 0xA5A5_5A5A at input position 1 and zeros elsewhere. Required: 0xA5A5_5A5A appears at natural bin 512, i.e. 512 ce after o_sync.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output stages: size defaults, reorder FSM
// encoding and the bit-reversal permutation used for address generation.
package fft_pkg;

  localparam int LGSIZE_DEF = 10;
  localparam int WIDTH_DEF  = 32;

  // Widest index bitrev() can permute; frames up to 2^16 points.
  localparam int BITREV_MAX = 16;

  localparam logic [1:0] WAIT_SYNC = 2'd0;
  localparam logic [1:0] FILL      = 2'd1;
  localparam logic [1:0] RUN       = 2'd2;

  // Reverses the low nbits of v (bit i -> bit nbits-1-i); upper bits return 0.
  // With a constant nbits this reduces to pure wiring.
  function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] v,
                                                   input int nbits);
    logic [BITREV_MAX-1:0] r;
    logic [BITREV_MAX-1:0] vs;
    r  = '0;
    vs = v;
    for (int i = 0; i < BITREV_MAX; i++) begin
      if (i < nbits) begin
        r  = {r[BITREV_MAX-2:0], vs[0]};
        vs = vs >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_ram.sv
// Simple dual-port RAM for the reorder ping-pong buffer: one write port and
// one registered read port, both qualified by the pipeline clock enable.
module fft_bitrev_ram
  import fft_pkg::*;
#(
  parameter int AW    = LGSIZE_DEF + 1,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_ce,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem [0:(1<<AW)-1];

  // NOTE: the array is deliberately left out of reset so it maps onto block
  // RAM; the FSM guarantees nothing is read before it has been written.
  always_ff @(posedge i_clk) begin
    if (i_ce && i_we)
      mem[i_waddr] <= i_wdata;
  end

  // Output register doubles as the stage's o_out register, hence the reset.
  always_ff @(posedge i_clk) begin
    if (i_reset)
      o_rdata <= '0;
    else if (i_ce && i_re)
      o_rdata <= mem[i_raddr];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT output frames into natural frequency order using
// a two-bank buffer: one bank fills while the other is read out permuted.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int LGSIZE = LGSIZE_DEF,
  parameter int WIDTH  = WIDTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_in,
  input  logic             i_sync,
  output logic [WIDTH-1:0] o_out,
  output logic             o_sync
);

  localparam logic [LGSIZE:0] ADDR_ONE = (LGSIZE+1)'(1);

  logic [1:0]        state;
  logic [LGSIZE:0]   wr_addr;
  logic [LGSIZE:0]   rd_addr;
  logic [LGSIZE-1:0] rd_pos;
  logic              wr_en;
  logic              rd_en;

  // Reset wins over a coincident i_ce; before lock only a sync'd sample lands.
  assign wr_en = i_ce && !i_reset && ((state != WAIT_SYNC) || i_sync);
  assign rd_en = i_ce && (state == RUN);

  // Natural bin k of the idle bank lives at position bitrev(k).
  assign rd_pos  = LGSIZE'(bitrev(BITREV_MAX'(wr_addr[LGSIZE-1:0]), LGSIZE));
  assign rd_addr = {~wr_addr[LGSIZE], rd_pos};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= WAIT_SYNC;
      wr_addr <= '0;
      o_sync  <= 1'b0;
    end else if (i_ce) begin
      o_sync <= (state == RUN) && (wr_addr[LGSIZE-1:0] == '0);
      case (state)
        WAIT_SYNC: begin
          if (i_sync) begin
            wr_addr <= ADDR_ONE;
            state   <= FILL;
          end
        end
        FILL: begin
          wr_addr <= wr_addr + ADDR_ONE;
          if (wr_addr[LGSIZE-1:0] == '1)
            state <= RUN;
        end
        RUN: begin
          // Frame alignment is locked: later i_sync pulses are ignored.
          wr_addr <= wr_addr + ADDR_ONE;
        end
        default: begin
          state   <= WAIT_SYNC;
          wr_addr <= '0;
        end
      endcase
    end
  end

  fft_bitrev_ram #(
    .AW    (LGSIZE + 1),
    .WIDTH (WIDTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_ce    (i_ce),
    .i_we    (wr_en),
    .i_waddr (wr_addr),
    .i_wdata (i_in),
    .i_re    (rd_en),
    .i_raddr (rd_addr),
    .o_rdata (o_out)
  );

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder: an 8-point instance driven from
// a vector table and a scoreboard, plus a 1024-point instance for bin mapping.
module tb_fft_bitrev_reorder;

  localparam int W  = 32;
  localparam int LG = 3;
  localparam int N  = 1 << LG;
  localparam int LB = 10;
  localparam int NB = 1 << LB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst3 = 1'b1, ce3 = 1'b0, sync3 = 1'b0;
  logic [W-1:0] in3 = '0, out3;
  logic         osync3;
  logic         rst10 = 1'b1, ce10 = 1'b0, sync10 = 1'b0;
  logic [W-1:0] in10 = '0, out10;
  logic         osync10;

  fft_bitrev_reorder #(.LGSIZE(LG), .WIDTH(W)) dut3 (
    .i_clk(clk), .i_reset(rst3), .i_ce(ce3), .i_in(in3), .i_sync(sync3),
    .o_out(out3), .o_sync(osync3)
  );

  fft_bitrev_reorder #(.LGSIZE(LB), .WIDTH(W)) dut10 (
    .i_clk(clk), .i_reset(rst10), .i_ce(ce10), .i_in(in10), .i_sync(sync10),
    .o_out(out10), .o_sync(osync10)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int br3(input int v);
    int r = 0;
    for (int i = 0; i < LG; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  // Scoreboard model of the 8-point instance.
  typedef struct {
    logic [W-1:0] data;
    logic         sync;
  } exp_t;

  exp_t         sb[$];
  bit           locked;
  int           pos, frames, ce_cnt, sync_ce, first_osync_ce;
  logic [W-1:0] frame_buf [N];
  logic [W-1:0] held;
  logic         held_sync;

  task automatic step(input logic rst, input logic ce, input logic sync,
                      input logic [W-1:0] din, input string tag);
    rst3 = rst; ce3 = ce; sync3 = sync; in3 = din;
    if (rst) begin
      sb.delete();
      locked = 0; pos = 0; frames = 0; first_osync_ce = -1;
      held = '0; held_sync = 1'b0;
    end else if (ce) begin
      ce_cnt++;
      if (frames > 0) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL %s: scoreboard empty got %h expected queued sample", tag, out3);
        end else begin
          exp_t e;
          e = sb.pop_front();
          held = e.data; held_sync = e.sync;
        end
      end else begin
        held_sync = 1'b0;
      end
      if (!locked && sync) begin
        locked = 1; pos = 0; sync_ce = ce_cnt;
      end
      if (locked) begin
        frame_buf[pos] = din;
        pos++;
        if (pos == N) begin
          for (int k = 0; k < N; k++) sb.push_back('{frame_buf[br3(k)], (k == 0)});
          pos = 0; frames++;
        end
      end
    end
    @(posedge clk); #1;
    if (osync3 && first_osync_ce < 0) first_osync_ce = ce_cnt;
    check({tag, " out"}, out3, held);
    check({tag, " sync"}, W'(osync3), W'(held_sync));
  endtask

  // Drives nfr sync'd frames; -1 disables the spurious sync / ce gap / reset.
  task automatic run_frames(input int nfr, input int spur_f, input int spur_p,
                            input int gap_f, input int gap_p,
                            input int rst_f, input int rst_p, input string tag);
    for (int f = 0; f < nfr; f++) begin
      for (int p = 0; p < N; p++) begin
        if (f == gap_f && p == gap_p)
          repeat (3) step(1'b0, 1'b0, 1'b0, W'($urandom), {tag, " gap"});
        if (f == rst_f && p == rst_p) begin
          step(1'b1, 1'b1, 1'b1, W'($urandom), {tag, " reset"});
          return;
        end
        step(1'b0, 1'b1, (p == 0) || (f == spur_f && p == spur_p), W'($urandom), tag);
      end
    end
  endtask

  typedef struct {
    logic         sync;
    logic [W-1:0] din;
    logic [W-1:0] exp_out;
    logic         exp_sync;
  } vec_t;

  vec_t tbl [3*N];
  int   bro [N] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int   cnt;
  bit   found;

  initial begin
    // Table: bit-reversed ramp frames must come out as 0..7, from the 9th ce.
    for (int r = 0; r < 3*N; r++) begin
      tbl[r].sync     = ((r % N) == 0);
      tbl[r].din      = W'(bro[r % N]);
      tbl[r].exp_out  = (r < N) ? '0 : W'(r % N);
      tbl[r].exp_sync = (r >= N) && ((r % N) == 0);
    end
    ce3 = 1'b1; rst3 = 1'b1;
    @(posedge clk); #1;
    check("t1 reset out", out3, '0);
    check("t1 reset sync", W'(osync3), '0);
    rst3 = 1'b0;
    for (int r = 0; r < 3*N; r++) begin
      sync3 = tbl[r].sync; in3 = tbl[r].din;
      @(posedge clk); #1;
      check($sformatf("t1 row%0d out", r), out3, tbl[r].exp_out);
      check($sformatf("t1 row%0d sync", r), W'(osync3), W'(tbl[r].exp_sync));
    end

    // Unsync'd samples are discarded; first o_sync exactly 8 ce after i_sync.
    ce_cnt = 0;
    step(1'b1, 1'b0, 1'b0, '0, "t2 reset");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, W'($urandom), "t2 presync");
    run_frames(3, -1, -1, -1, -1, -1, -1, "t2");
    check("t2 first osync latency", W'(first_osync_ce - sync_ce), W'(N));

    // Three ce-low cycles mid-frame while running.
    step(1'b1, 1'b0, 1'b0, '0, "t3 reset");
    run_frames(4, -1, -1, 2, 4, -1, -1, "t3");

    // Spurious sync at position 3 of frame 2 must not shift alignment.
    step(1'b1, 1'b0, 1'b0, '0, "t4 reset");
    run_frames(5, 2, 3, -1, -1, -1, -1, "t4");

    // Reset (with i_ce high) at position 5 of frame 2, then idle, then relock.
    step(1'b1, 1'b0, 1'b0, '0, "t5 reset");
    run_frames(3, -1, -1, -1, -1, 2, 5, "t5");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, W'($urandom), "t5 idle");
    run_frames(3, -1, -1, -1, -1, -1, -1, "t5 relock");

    // 1024-point: input position 1 must surface at natural bin 512.
    ce10 = 1'b1; rst10 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t6 reset out", out10, '0);
    rst10 = 1'b0;
    for (int p = 0; p < NB; p++) begin
      sync10 = (p == 0);
      in10   = (p == 1) ? 32'hA5A5_5A5A : '0;
      @(posedge clk); #1;
    end
    sync10 = 1'b0; in10 = '0;
    cnt = 0; found = 0;
    while (!found && cnt < 3 * NB) begin
      @(posedge clk); #1;
      cnt++;
      if (osync10) found = 1;
    end
    check("t6 osync latency", W'(cnt), W'(1));
    if (found) begin
      check("t6 bin0", out10, '0);
      for (int j = 1; j <= NB/2; j++) begin
        @(posedge clk); #1;
        if (j == NB/2 - 1) check("t6 bin511", out10, '0);
        if (j == NB/2)     check("t6 bin512", out10, 32'hA5A5_5A5A);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
